// File: rtl/cdb_arbiter_pkg.sv
// Global configuration and CDB shared types for the backend.
// Pure declarations; no logic, no latency.
// No flow control here; consumers of cdb_entry_t define their own handshake.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{XLEN: 32};

endpackage

package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  // One broadcast result as seen by the RS and ROB CDB inputs.
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] val;
  } cdb_entry_t;

  // (a + b) mod n for operands already below n; avoids a real divider in the scan.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/cdb_arbiter_wb_fifo.sv
// Per-source writeback result buffer, DEPTH entries, head visible on dout.
// Latency: a push at edge N is visible at dout/count after edge N.
// Backpressure: caller must not push when count==DEPTH; extra pushes/pops are ignored.
module wb_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: buffers FU results per source, grants up to CDB_W heads per cycle round-robin.
// Latency: result accepted at edge N reaches the CDB registers at edge N+1 if a lane is free.
// Backpressure: src_ready_o drops when a source FIFO is full (registered count only).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter config_pkg::cfg_t    Cfg           = config_pkg::EmptyCfg,
  parameter int                  NUM_SRC       = 6,
  parameter int                  CDB_W         = 4,
  parameter int                  DATA_W        = Cfg.XLEN,
  parameter int                  TAG_W         = CDB_TAG_W,
  parameter int                  FIFO_DEPTH    = 2,
  parameter logic [NUM_SRC-1:0]  WAKE_SRC_MASK = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic [NUM_SRC-1:0]  src_valid_i,
  input  logic [TAG_W-1:0]    src_tag_i [0:NUM_SRC-1],
  input  logic [DATA_W-1:0]   src_val_i [0:NUM_SRC-1],
  output logic [NUM_SRC-1:0]  src_ready_o,
  output logic [CDB_W-1:0]    cdb_valid,
  output logic [TAG_W-1:0]    cdb_tag [0:CDB_W-1],
  output logic [DATA_W-1:0]   cdb_val [0:CDB_W-1],
  output logic [CDB_W-1:0]    cdb_wakeup_mask
);

  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LIDX_W = (CDB_W > 1) ? $clog2(CDB_W) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W  = TAG_W + DATA_W;

  logic [CNT_W-1:0]   fifo_count [NUM_SRC];
  logic [ENT_W-1:0]   fifo_dout  [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_push;
  logic [NUM_SRC-1:0] fifo_pop;

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   next_rr;
  logic               any_grant;
  logic [CDB_W-1:0]   grant_vld;
  logic [SRC_W-1:0]   grant_src [CDB_W];

  logic [SRC_W-1:0]   scan_idx;
  logic [LIDX_W-1:0]  scan_lane;
  logic               scan_full;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Ready comes from the registered count, so a same-cycle pop never frees a slot early.
    assign src_ready_o[i] = (fifo_count[i] != CNT_W'(FIFO_DEPTH));
    assign fifo_push[i]   = src_valid_i[i] & src_ready_o[i];

    wb_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_i),
      .push  (fifo_push[i]),
      .din   ({src_tag_i[i], src_val_i[i]}),
      .pop   (fifo_pop[i]),
      .dout  (fifo_dout[i]),
      .count (fifo_count[i])
    );
  end

  // Grant scan: walk sources from rr_ptr, hand each non-empty head the next free lane.
  always_comb begin
    grant_vld = '0;
    fifo_pop  = '0;
    any_grant = 1'b0;
    next_rr   = rr_ptr;
    scan_idx  = '0;
    scan_lane = '0;
    scan_full = 1'b0;
    for (int k = 0; k < CDB_W; k++) grant_src[k] = '0;
    for (int o = 0; o < NUM_SRC; o++) begin
      scan_idx = SRC_W'(wrap_add(int'(rr_ptr), o, NUM_SRC));
      if (!scan_full && (fifo_count[scan_idx] != '0)) begin
        grant_vld[scan_lane] = 1'b1;
        grant_src[scan_lane] = scan_idx;
        fifo_pop[scan_idx]   = 1'b1;
        any_grant            = 1'b1;
        next_rr              = SRC_W'(wrap_add(int'(scan_idx), 1, NUM_SRC));
        if (scan_lane == LIDX_W'(CDB_W - 1)) scan_full = 1'b1;
        else                                 scan_lane = scan_lane + 1'b1;
      end
    end
  end

  // CDB lane registers and round-robin pointer; flush clears validity but keeps stale payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid       <= '0;
      cdb_wakeup_mask <= '0;
      rr_ptr          <= '0;
      for (int k = 0; k < CDB_W; k++) begin
        cdb_tag[k] <= '0;
        cdb_val[k] <= '0;
      end
    end else if (flush_i) begin
      cdb_valid       <= '0;
      cdb_wakeup_mask <= '0;
      rr_ptr          <= '0;
    end else begin
      cdb_valid <= grant_vld;
      for (int k = 0; k < CDB_W; k++) begin
        if (grant_vld[k]) begin
          cdb_tag[k]         <= fifo_dout[grant_src[k]][ENT_W-1:DATA_W];
          cdb_val[k]         <= fifo_dout[grant_src[k]][DATA_W-1:0];
          cdb_wakeup_mask[k] <= WAKE_SRC_MASK[grant_src[k]];
        end else begin
          cdb_wakeup_mask[k] <= 1'b0;
        end
      end
      if (any_grant) rr_ptr <= next_rr;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, hand sequences, random vs queue model.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// The reference model keeps one queue per source and re-derives grants from the rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NS = 6;
  localparam int NL = 4;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam logic [NS-1:0] WAKE = 6'b001111;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [NS-1:0] src_valid;
  logic [TW-1:0] src_tag [0:NS-1];
  logic [DW-1:0] src_val [0:NS-1];
  logic [NS-1:0] src_ready;
  logic [NL-1:0] cdb_valid;
  logic [TW-1:0] cdb_tag [0:NL-1];
  logic [DW-1:0] cdb_val [0:NL-1];
  logic [NL-1:0] cdb_wakeup_mask;

  cdb_arbiter #(
    .NUM_SRC       (NS),
    .CDB_W         (NL),
    .TAG_W         (TW),
    .FIFO_DEPTH    (2),
    .WAKE_SRC_MASK (WAKE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush),
    .src_valid_i     (src_valid),
    .src_tag_i       (src_tag),
    .src_val_i       (src_val),
    .src_ready_o     (src_ready),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_val         (cdb_val),
    .cdb_wakeup_mask (cdb_wakeup_mask)
  );

  always #5 clk = ~clk;

  // Reference model state.
  cdb_entry_t    q [NS][$];
  int            rr;
  logic [NL-1:0] m_valid;
  logic [NL-1:0] m_mask;
  cdb_entry_t    m_lane [NL];

  int            errors = 0;
  int            checks = 0;
  logic [63:0]   banned;
  int            bad_seen;
  int            accepted;
  int            bcast;

  typedef struct {
    logic [NS-1:0] vld;
    logic          fl;
    logic [NL-1:0] e_valid;
    logic [TW-1:0] e_tag0;
    logic [TW-1:0] e_tag1;
    logic [NL-1:0] e_mask;
    logic [NS-1:0] e_ready;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int sz [NS];
    int n;
    int last;
    int s;
    if (rst || flush) begin
      for (int i = 0; i < NS; i++) q[i].delete();
      rr      = 0;
      m_valid = '0;
      m_mask  = '0;
      if (rst) for (int k = 0; k < NL; k++) m_lane[k] = '0;
      return;
    end
    for (int i = 0; i < NS; i++) sz[i] = q[i].size();
    n       = 0;
    last    = -1;
    m_valid = '0;
    m_mask  = '0;
    for (int o = 0; o < NS; o++) begin
      s = (rr + o) % NS;
      if (sz[s] > 0 && n < NL) begin
        m_lane[n]  = q[s].pop_front();
        m_valid[n] = 1'b1;
        m_mask[n]  = WAKE[s];
        last       = s;
        n++;
      end
    end
    if (last >= 0) rr = (last + 1) % NS;
    for (int i = 0; i < NS; i++) begin
      if (src_valid[i] && sz[i] < 2) begin
        q[i].push_back('{tag: src_tag[i], val: src_val[i]});
        accepted++;
      end
    end
  endtask

  // One clock: model update, then compare every DUT output with the model.
  task automatic tick();
    logic [NS-1:0] e_ready;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NS; i++) e_ready[i] = (q[i].size() < 2);
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("wakeup_mask", 64'(cdb_wakeup_mask), 64'(m_mask));
    chk("src_ready", 64'(src_ready), 64'(e_ready));
    for (int k = 0; k < NL; k++) begin
      if (m_valid[k]) begin
        chk($sformatf("lane%0d_tag", k), 64'(cdb_tag[k]), 64'(m_lane[k].tag));
        chk($sformatf("lane%0d_val", k), 64'(cdb_val[k]), 64'(m_lane[k].val));
      end
      if (cdb_valid[k]) begin
        bcast++;
        if (banned[cdb_tag[k]]) bad_seen++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bool_init();
  end

  task automatic bool_init();
    int drop_seen;
    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    banned    = '0;
    bad_seen  = 0;
    accepted  = 0;
    bcast     = 0;
    for (int i = 0; i < NS; i++) begin
      src_tag[i] = TW'(40 + i);
      src_val[i] = 32'h5000_0000 + i;
    end
    @(negedge clk);

    // Reset held two cycles with every source valid.
    src_valid = '1;
    tick();
    chk("rst_ready", 64'(src_ready), 64'h3f);
    chk("rst_tag0", 64'(cdb_tag[0]), 64'h0);
    tick();
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    rst       = 1'b0;
    src_valid = '0;
    tick();
    tick();
    chk("rst_no_xfer", 64'(cdb_valid), 64'h0);

    // Single result from src2.
    src_valid  = 6'b000100;
    src_tag[2] = 6'd5;
    src_val[2] = 32'hDEAD_BEEF;
    tick();
    src_valid = '0;
    chk("single_not_yet", 64'(cdb_valid), 64'h0);
    tick();
    chk("single_valid", 64'(cdb_valid), 64'b0001);
    chk("single_tag", 64'(cdb_tag[0]), 64'd5);
    chk("single_val", 64'(cdb_val[0]), 64'hDEAD_BEEF);
    chk("single_wake", 64'(cdb_wakeup_mask[0]), 64'd1);
    tick();
    chk("single_once", 64'(cdb_valid), 64'h0);

    // Directed table from a clean reset: rr_ptr=0, all FIFOs empty, tag of src i = i+10.
    do_reset();
    for (int i = 0; i < NS; i++) begin
      src_tag[i] = TW'(10 + i);
      src_val[i] = 32'hA000_0000 + i;
    end
    tbl[0]  = '{6'b111111, 1'b0, 4'b0000, 6'd0,  6'd0,  4'b0000, 6'b111111};
    tbl[1]  = '{6'b000000, 1'b0, 4'b1111, 6'd10, 6'd11, 4'b1111, 6'b111111};
    tbl[2]  = '{6'b000000, 1'b0, 4'b0011, 6'd14, 6'd15, 4'b0000, 6'b111111};
    tbl[3]  = '{6'b000000, 1'b0, 4'b0000, 6'd0,  6'd0,  4'b0000, 6'b111111};
    tbl[4]  = '{6'b000100, 1'b0, 4'b0000, 6'd0,  6'd0,  4'b0000, 6'b111111};
    tbl[5]  = '{6'b000000, 1'b0, 4'b0001, 6'd12, 6'd0,  4'b0001, 6'b111111};
    tbl[6]  = '{6'b011000, 1'b0, 4'b0000, 6'd0,  6'd0,  4'b0000, 6'b111111};
    tbl[7]  = '{6'b000000, 1'b0, 4'b0011, 6'd13, 6'd14, 4'b0001, 6'b111111};
    tbl[8]  = '{6'b000001, 1'b1, 4'b0000, 6'd0,  6'd0,  4'b0000, 6'b111111};
    tbl[9]  = '{6'b000000, 1'b0, 4'b0000, 6'd0,  6'd0,  4'b0000, 6'b111111};
    tbl[10] = '{6'b111111, 1'b0, 4'b0000, 6'd0,  6'd0,  4'b0000, 6'b111111};
    tbl[11] = '{6'b111111, 1'b0, 4'b1111, 6'd10, 6'd11, 4'b1111, 6'b001111};
    tbl[12] = '{6'b000000, 1'b0, 4'b1111, 6'd14, 6'd15, 4'b1100, 6'b111111};
    tbl[13] = '{6'b000000, 1'b0, 4'b1111, 6'd12, 6'd13, 4'b0011, 6'b111111};
    tbl[14] = '{6'b000000, 1'b0, 4'b0000, 6'd0,  6'd0,  4'b0000, 6'b111111};
    for (int v = 0; v < 15; v++) begin
      src_valid = tbl[v].vld;
      flush     = tbl[v].fl;
      tick();
      chk($sformatf("tbl%0d_valid", v), 64'(cdb_valid), 64'(tbl[v].e_valid));
      chk($sformatf("tbl%0d_mask", v), 64'(cdb_wakeup_mask), 64'(tbl[v].e_mask));
      chk($sformatf("tbl%0d_ready", v), 64'(src_ready), 64'(tbl[v].e_ready));
      if (tbl[v].e_valid[0]) chk($sformatf("tbl%0d_tag0", v), 64'(cdb_tag[0]), 64'(tbl[v].e_tag0));
      if (tbl[v].e_valid[1]) chk($sformatf("tbl%0d_tag1", v), 64'(cdb_tag[1]), 64'(tbl[v].e_tag1));
    end
    flush     = 1'b0;
    src_valid = '0;

    // Backpressure: every source pushes every cycle for 50 cycles, then drain.
    do_reset();
    accepted  = 0;
    bcast     = 0;
    drop_seen = 0;
    for (int c = 0; c < 50; c++) begin
      src_valid = '1;
      for (int i = 0; i < NS; i++) begin
        src_tag[i] = TW'(c * NS + i);
        src_val[i] = {16'(i), 16'(c)};
      end
      tick();
      if (!src_ready[0]) drop_seen = 1;
    end
    src_valid = '0;
    for (int c = 0; c < 8; c++) tick();
    chk("bp_src0_ready_drop", 64'(drop_seen), 64'd1);
    chk("bp_conservation", 64'(bcast), 64'(accepted));

    // Flush with 3 buffered, 2 on the CDB, and a discarded src1 push of tag 9.
    do_reset();
    src_valid  = 6'b000011;
    src_tag[0] = 6'd20;
    src_tag[1] = 6'd21;
    tick();
    src_valid  = 6'b000111;
    src_tag[0] = 6'd22;
    src_tag[1] = 6'd23;
    src_tag[2] = 6'd24;
    tick();
    chk("fl_pre_valid", 64'(cdb_valid), 64'b0011);
    banned     = '0;
    banned[22] = 1'b1;
    banned[23] = 1'b1;
    banned[24] = 1'b1;
    banned[9]  = 1'b1;
    bad_seen   = 0;
    flush      = 1'b1;
    src_valid  = 6'b000010;
    src_tag[1] = 6'd9;
    tick();
    flush     = 1'b0;
    src_valid = '0;
    chk("fl_valid_cleared", 64'(cdb_valid), 64'h0);
    chk("fl_mask_cleared", 64'(cdb_wakeup_mask), 64'h0);
    for (int c = 0; c < 4; c++) tick();
    src_valid  = 6'b100001;
    src_tag[5] = 6'd30;
    src_tag[0] = 6'd31;
    tick();
    src_valid = '0;
    tick();
    chk("fl_rr_valid", 64'(cdb_valid), 64'b0011);
    chk("fl_rr_lane0_src0", 64'(cdb_tag[0]), 64'd31);
    chk("fl_rr_lane1_src5", 64'(cdb_tag[1]), 64'd30);
    chk("fl_banned_tags", 64'(bad_seen), 64'd0);
    banned = '0;

    // Random traffic against the model, with occasional flush and reset.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      src_valid = NS'($urandom);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NS; i++) begin
        src_tag[i] = TW'($urandom);
        src_val[i] = $urandom;
      end
      tick();
    end
    rst       = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    for (int c = 0; c < 6; c++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

endmodule
